program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter WORDS, default 16: program memory depth; address width is log2(WORDS)=4.
REQ-002 Parameter DATA_W, default 7: command word width (3-bit opcode, 4-bit operand).
REQ-003 CLK  in  1  single clock; all state changes on the rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 LOAD_EN  in  1  level request to (re)load the program; must stay high for the whole load.
REQ-006 SER_DATA  in  1  serial program bit, MSB first.
REQ-007 SER_VALID  in  1  one-cycle strobe; SER_DATA is sampled on cycles where it is high.
REQ-008 MEM_ADDR  in  4  fetch address from the processor core.
REQ-009 MEM_DATA  out  7  command word returned to the core.
REQ-010 CPU_RESET  out  1  active-high hold-reset for the core.
REQ-011 LOAD_DONE  out  1  high while a complete, parity-clean program is resident.
REQ-012 LOAD_ERR  out  1  high after a parity failure or aborted load, until the next load starts.

Function
REQ-013 States: IDLE, LOAD, RUN, ERROR; state is registered.
REQ-014 Frame = 8 bits: bits [7:1] = command word, bit [0] = odd parity over all 8 bits.
REQ-015 IDLE/RUN/ERROR with LOAD_EN=1 -> LOAD next cycle; bit counter, word counter and shift register clear to 0; LOAD_ERR clears.
REQ-016 In LOAD, each SER_VALID=1 cycle shifts SER_DATA into the frame register LSB side; bit counter increments 0..7.
REQ-017 On the 8th bit (SER_VALID=1 with bit counter=7): parity odd -> mem[word counter] <= frame[7:1] on that edge, word counter +1; parity even -> ERROR, no write.
REQ-018 8th bit of word 15 with good parity -> RUN; word counter wraps to 0; no extra cycle of latency.
REQ-019 LOAD_EN=0 while in LOAD -> ERROR next cycle, regardless of bit position; partial frame discarded; words already written remain.
REQ-020 SER_VALID outside LOAD is ignored.
REQ-021 RUN with LOAD_EN=0: hold; ERROR with LOAD_EN=0: hold.
REQ-022 MEM_DATA = mem[MEM_ADDR], combinational, in IDLE and RUN; forced to 7'h00 in LOAD and ERROR.
REQ-023 CPU_RESET = 1 in LOAD and ERROR, 0 in IDLE and RUN.
REQ-024 LOAD_DONE = 1 only in RUN; LOAD_ERR = 1 only in ERROR.
REQ-025 Memory writes only per REQ-017; a read and a write in the same cycle are not possible because reads are masked in LOAD.

Reset
REQ-026 RESET=1 asynchronously forces IDLE, all counters and frame register to 0, all 16 memory words to 7'h00.
REQ-027 During and after reset: MEM_DATA=7'h00, CPU_RESET=0, LOAD_DONE=0, LOAD_ERR=0.
REQ-028 RESET mid-load discards the load entirely; a new load needs LOAD_EN=1 after RESET is released.

Structure
REQ-029 Package loader_pkg holds WORDS, DATA_W, FRAME_W=8 and the state enumeration (IDLE, LOAD, RUN, ERROR).
REQ-030 One sub-module serial_frame_rx: shift register, bit counter and parity check; outputs frame word, frame_strobe and parity_ok.
REQ-031 Memory is a flop array inside program_loader; no vendor RAM.

Verification
REQ-032 Reset, then MEM_ADDR sweep 0..15 -> MEM_DATA=7'h00 every address, CPU_RESET=0, flags 0.
REQ-033 LOAD_EN=1, 16 good frames with word n=7'h10+n (gaps of 0-3 cycles between strobes) -> RUN on the edge of the last bit; LOAD_DONE=1, CPU_RESET=0; MEM_ADDR=5 -> MEM_DATA=7'h15.
REQ-034 Word 3 sent with even parity -> ERROR on that edge, LOAD_ERR=1, CPU_RESET=1, MEM_DATA=7'h00; mem[3] keeps its previous value.
REQ-035 LOAD_EN dropped after 4 bits of word 9 -> ERROR next cycle; LOAD_EN=1 again -> LOAD, counters 0, LOAD_ERR=0.
REQ-036 RESET pulsed after word 7 of a load -> IDLE immediately, all words read 7'h00, LOAD_DONE=0.
REQ-037 SER_VALID pulses in RUN with LOAD_EN=0 -> memory and outputs unchanged.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the serial program loader.
package loader_pkg;

    localparam int unsigned WORDS   = 16;
    localparam int unsigned DATA_W  = 7;
    localparam int unsigned FRAME_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StError
    } state_e;

endpackage

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: MSB-first shift register, bit counter and odd-parity check.
module serial_frame_rx
    import loader_pkg::*;
#(
    parameter int unsigned FRAME_BITS = FRAME_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  ser_data,
    input  logic                  ser_valid,
    output logic [FRAME_BITS-2:0] frame_word,
    output logic                  frame_strobe,
    output logic                  parity_ok
);

    localparam int unsigned CW = $clog2(FRAME_BITS);

    // The final bit is consumed combinationally, so only FRAME_BITS-1 bits are stored.
    logic [FRAME_BITS-2:0] shift_q;
    logic [CW-1:0]         bit_cnt_q;
    logic                  last_bit;

    assign last_bit = bit_cnt_q == CW'(FRAME_BITS - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else if (clear) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else if (enable && ser_valid) begin
            shift_q   <= {shift_q[FRAME_BITS-3:0], ser_data};
            bit_cnt_q <= last_bit ? '0 : bit_cnt_q + CW'(1);
        end
    end

    assign frame_word   = shift_q;
    assign frame_strobe = enable && ser_valid && last_bit;
    assign parity_ok    = ^{shift_q, ser_data};

endmodule

// File: rtl/program_loader.sv
// Loads a program serially into a flop-array memory, holding the core in reset until
// a complete, parity-clean image is resident.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned WORDS  = loader_pkg::WORDS,
    parameter int unsigned DATA_W = loader_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_en,
    input  logic                     ser_data,
    input  logic                     ser_valid,
    input  logic [$clog2(WORDS)-1:0] mem_addr,
    output logic [DATA_W-1:0]        mem_data,
    output logic                     cpu_reset,
    output logic                     load_done,
    output logic                     load_err
);

    localparam int unsigned AW = $clog2(WORDS);

    state_e            state_q, state_d;
    logic [AW-1:0]     word_cnt_q;
    logic [DATA_W-1:0] mem_q [WORDS];

    logic              rx_clear, rx_enable;
    logic [DATA_W-1:0] frame_word;
    logic              frame_strobe, parity_ok;
    logic              word_good, last_word;

    // Counters sit at zero outside LOAD, so entering LOAD always starts clean.
    assign rx_clear  = state_q != StLoad;
    // Dropping load_en aborts the load, taking priority over a coincident 8th bit.
    assign rx_enable = (state_q == StLoad) && load_en;
    assign word_good = frame_strobe && parity_ok;
    assign last_word = word_cnt_q == AW'(WORDS - 1);

    serial_frame_rx #(
        .FRAME_BITS (DATA_W + 1)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .clear        (rx_clear),
        .enable       (rx_enable),
        .ser_data     (ser_data),
        .ser_valid    (ser_valid),
        .frame_word   (frame_word),
        .frame_strobe (frame_strobe),
        .parity_ok    (parity_ok)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StRun, StError: begin
                if (load_en) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (!load_en) begin
                    state_d = StError;
                end else if (frame_strobe && !parity_ok) begin
                    state_d = StError;
                end else if (word_good && last_word) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt_q <= '0;
            for (int unsigned i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (rx_clear) begin
            word_cnt_q <= '0;
        end else if (word_good) begin
            mem_q[word_cnt_q] <= frame_word;
            word_cnt_q        <= last_word ? '0 : word_cnt_q + AW'(1);
        end
    end

    always_comb begin
        mem_data  = '0;
        cpu_reset = 1'b0;
        load_done = 1'b0;
        load_err  = 1'b0;
        unique case (state_q)
            StIdle:  mem_data = mem_q[mem_addr];
            StRun: begin
                mem_data  = mem_q[mem_addr];
                load_done = 1'b1;
            end
            StLoad:  cpu_reset = 1'b1;
            StError: begin
                cpu_reset = 1'b1;
                load_err  = 1'b1;
            end
            default: mem_data = '0;
        endcase
    end

endmodule
